// File: rtl/ether_rx.sv
// ether_rx: RMII receive front end.
// Finds preamble and SFD in the PHY dibit stream, then forwards post-SFD dibits
// in wire order as a registered valid/data stream with a one-cycle error pulse.
module ether_rx #(
  parameter int MIN_PREAMBLE     = 16,
  parameter int MAX_FRAME_DIBITS = 6088
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  localparam logic [4:0]  MIN_PRE = 5'(MIN_PREAMBLE);
  localparam logic [12:0] MAX_DAT = 13'(MAX_FRAME_DIBITS);

  state_t      state;
  logic [4:0]  pre_cnt;
  logic [12:0] dat_cnt;
  // Set by reset and cleared by the first crsdv=0 sample. While set, the
  // carrier episode that was in progress at reset is abandoned silently: no
  // err pulses, and stray 10/11 dibits in IDLE do not force DROP.
  logic        mute;

  // Receive FSM with counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pre_cnt <= '0;
      dat_cnt <= '0;
      axiov   <= 1'b0;
      axiod   <= 2'b00;
      err     <= 1'b0;
      mute    <= 1'b1;
    end else begin
      // NOTE: axiov and err default low every cycle so each is a single-cycle
      // pulse; axiod has no default and therefore holds its last value.
      axiov <= 1'b0;
      err   <= 1'b0;
      if (!crsdv) mute <= 1'b0;

      case (state)
        IDLE: begin
          if (crsdv) begin
            if (rxd == 2'b01) begin
              state   <= PREAMBLE;
              pre_cnt <= 5'd1;
            end else if (rxd[1] && !mute) begin
              state <= DROP;
              err   <= 1'b1;
            end
          end
        end

        PREAMBLE: begin
          if (!crsdv) begin
            state <= IDLE;
            err   <= !mute;
          end else begin
            case (rxd)
              2'b01: begin
                if (pre_cnt != 5'd31) pre_cnt <= pre_cnt + 5'd1;
              end
              2'b11: begin
                if (pre_cnt >= MIN_PRE) begin
                  state   <= DATA;
                  dat_cnt <= '0;
                end else begin
                  state <= DROP;
                  err   <= !mute;
                end
              end
              default: begin
                state <= DROP;
                err   <= !mute;
              end
            endcase
          end
        end

        DATA: begin
          if (!crsdv) begin
            state <= IDLE;
          end else if (dat_cnt == MAX_DAT) begin
            state <= DROP;
            err   <= !mute;
          end else begin
            axiov   <= 1'b1;
            axiod   <= rxd;
            dat_cnt <= dat_cnt + 13'd1;
          end
        end

        DROP: begin
          if (!crsdv) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ether_rx.sv
// tb_ether_rx: self-checking bench for ether_rx.
// Two instances share the inputs: A with default parameters, B with a short
// preamble minimum and an 8-dibit frame limit to reach truncation quickly.
module tb_ether_rx;

  localparam int MIN_A = 16;
  localparam int MAX_A = 6088;
  localparam int MIN_B = 5;
  localparam int MAX_B = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       crsdv;
  logic [1:0] rxd;
  logic       axiov_a, err_a, axiov_b, err_b;
  logic [1:0] axiod_a, axiod_b;

  ether_rx #(.MIN_PREAMBLE(MIN_A), .MAX_FRAME_DIBITS(MAX_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .crsdv(crsdv), .rxd(rxd),
    .axiov(axiov_a), .axiod(axiod_a), .err(err_a)
  );

  ether_rx #(.MIN_PREAMBLE(MIN_B), .MAX_FRAME_DIBITS(MAX_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .crsdv(crsdv), .rxd(rxd),
    .axiov(axiov_b), .axiod(axiod_b), .err(err_b)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       e;
  } obs_t;

  typedef struct {
    logic       c;
    logic [1:0] d;
    logic       ev;
    logic [1:0] ed;
    logic       ee;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] stim[$];
  obs_t       obs_a[$];
  obs_t       obs_b[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then record both instances' outputs
  // just after the rising edge that samples it.
  task automatic step(input logic c, input logic [1:0] d);
    obs_t o;
    @(negedge clk);
    crsdv = c;
    rxd   = d;
    @(posedge clk);
    #1;
    o.v = axiov_a; o.d = axiod_a; o.e = err_a; obs_a.push_back(o);
    o.v = axiov_b; o.d = axiod_b; o.e = err_b; obs_b.push_back(o);
  endtask

  // Reference model for one carrier episode (stim, then one crsdv=0 cycle),
  // derived from the frame rules: skip idle 00s, measure the 01 run, judge the
  // terminator, then forward up to max_dat dibits. Indices are stim positions;
  // index stim.size() is the carrier-off sample.
  task automatic check_ep(input string name, input int which,
                          input int min_pre, input int max_dat);
    obs_t o[$];
    int len, i, j, n, rest;
    int err_at, fwd_lo, fwd_n;
    int v_cnt, e_cnt, e_first, bad;
    logic exp_v;
    len = stim.size();
    err_at = -1; fwd_lo = 0; fwd_n = 0;
    i = 0;
    while (i < len && stim[i] == 2'b00) i++;
    if (i < len) begin
      if (stim[i] != 2'b01) begin
        err_at = i;
      end else begin
        n = 0; j = i;
        while (j < len && stim[j] == 2'b01) begin n++; j++; end
        if (j == len) err_at = len;
        else if (stim[j] == 2'b11 && n >= min_pre) begin
          rest   = len - j - 1;
          fwd_lo = j + 1;
          fwd_n  = (rest < max_dat) ? rest : max_dat;
          if (rest > max_dat) err_at = j + 1 + max_dat;
        end else err_at = j;
      end
    end
    if (which == 0) o = obs_a; else o = obs_b;
    v_cnt = 0; e_cnt = 0; e_first = -1; bad = 0;
    for (int k = 0; k < o.size(); k++) begin
      exp_v = (k >= fwd_lo) && (k < fwd_lo + fwd_n);
      if (o[k].v) v_cnt++;
      if (o[k].e) begin
        e_cnt++;
        if (e_first < 0) e_first = k;
      end
      if (o[k].v != exp_v) bad++;
      else if (exp_v && o[k].d != stim[k]) bad++;
    end
    check($sformatf("%s.%s.fwd_count", name, which == 0 ? "A" : "B"), v_cnt, fwd_n);
    check($sformatf("%s.%s.err_cycle", name, which == 0 ? "A" : "B"), e_first, err_at);
    check($sformatf("%s.%s.err_count", name, which == 0 ? "A" : "B"), e_cnt, (err_at >= 0) ? 1 : 0);
    check($sformatf("%s.%s.stream_mismatches", name, which == 0 ? "A" : "B"), bad, 0);
  endtask

  task automatic run_episode(input string name);
    obs_a.delete();
    obs_b.delete();
    foreach (stim[k]) step(1'b1, stim[k]);
    step(1'b0, 2'b00);
    check_ep(name, 0, MIN_A, MAX_A);
    check_ep(name, 1, MIN_B, MAX_B);
  endtask

  task automatic add_frame(input int n_pre, input logic [1:0] term, input int n_dat);
    for (int k = 0; k < n_pre; k++) stim.push_back(2'b01);
    stim.push_back(term);
    for (int k = 0; k < n_dat; k++) stim.push_back(2'($urandom_range(0, 3)));
  endtask

  vec_t       tbl[$];
  logic [1:0] good_data[8];
  int         v_sum, e_sum;

  initial begin
    vec_t t;
    good_data = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};

    // Good-frame vector table for instance A.
    for (int k = 0; k < 31; k++) begin
      t = '{c: 1'b1, d: 2'b01, ev: 1'b0, ed: 2'b00, ee: 1'b0}; tbl.push_back(t);
    end
    t = '{c: 1'b1, d: 2'b11, ev: 1'b0, ed: 2'b00, ee: 1'b0}; tbl.push_back(t);
    for (int k = 0; k < 8; k++) begin
      t = '{c: 1'b1, d: good_data[k], ev: 1'b1, ed: good_data[k], ee: 1'b0}; tbl.push_back(t);
    end
    t = '{c: 1'b0, d: 2'b00, ev: 1'b0, ed: 2'b00, ee: 1'b0}; tbl.push_back(t);

    // Reset state.
    rst_n = 1'b0; crsdv = 1'b0; rxd = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset.axiov", int'(axiov_a), 0);
    check("reset.axiod", int'(axiod_a), 0);
    check("reset.err",   int'(err_a),   0);
    check("reset.B.axiov", int'(axiov_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 2'b00);

    // Table-driven good frame.
    foreach (tbl[k]) begin
      step(tbl[k].c, tbl[k].d);
      check($sformatf("good.axiov[%0d]", k), int'(axiov_a), int'(tbl[k].ev));
      check($sformatf("good.err[%0d]", k),   int'(err_a),   int'(tbl[k].ee));
      if (tbl[k].ev) check($sformatf("good.axiod[%0d]", k), int'(axiod_a), int'(tbl[k].ed));
    end

    // Hand-written corner sequences, all checked against the model.
    stim.delete(); add_frame(10, 2'b11, 4);  run_episode("short_pre");
    stim.delete(); add_frame(31, 2'b11, 6);  run_episode("after_short");
    stim.delete(); add_frame(15, 2'b11, 3);  run_episode("pre_15");
    stim.delete(); add_frame(16, 2'b11, 3);  run_episode("pre_16");
    stim.delete(); add_frame(20, 2'b10, 0); stim.push_back(2'b11);
    for (int k = 0; k < 4; k++) stim.push_back(2'b00);
    run_episode("bad_pre");
    stim.delete(); add_frame(16, 2'b11, 12); run_episode("trunc");
    stim.delete(); add_frame(16, 2'b11, 8);  run_episode("exact_max");
    stim.delete(); stim.push_back(2'b00); stim.push_back(2'b00); add_frame(17, 2'b11, 5);
    run_episode("idle_00");
    stim.delete(); stim.push_back(2'b11); stim.push_back(2'b01); run_episode("idle_11");
    stim.delete(); for (int k = 0; k < 20; k++) stim.push_back(2'b01);
    run_episode("carrier_drop_pre");
    stim.delete(); add_frame(20, 2'b11, 0);  run_episode("empty_frame");
    stim.delete(); add_frame(18, 2'b11, 7);  run_episode("b2b_1");
    stim.delete(); add_frame(18, 2'b11, 7);  run_episode("b2b_2");

    // Reset mid-DATA, then a remainder containing a stray 01.
    for (int k = 0; k < 20; k++) step(1'b1, 2'b01);
    step(1'b1, 2'b11);
    for (int k = 0; k < 3; k++) step(1'b1, good_data[k + 1]);
    @(negedge clk);
    rst_n = 1'b0; crsdv = 1'b1; rxd = 2'b10;
    @(posedge clk);
    #1;
    check("rst_mid.axiov", int'(axiov_a), 0);
    check("rst_mid.axiod", int'(axiod_a), 0);
    check("rst_mid.err",   int'(err_a),   0);
    check("rst_mid.B.axiod", int'(axiod_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    obs_a.delete(); obs_b.delete();
    step(1'b1, 2'b11); step(1'b1, 2'b10); step(1'b1, 2'b01); step(1'b1, 2'b00);
    step(1'b1, 2'b11); step(1'b1, 2'b01); step(1'b1, 2'b10);
    step(1'b0, 2'b00);
    v_sum = 0; e_sum = 0;
    foreach (obs_a[k]) begin
      v_sum += int'(obs_a[k].v) + int'(obs_b[k].v);
      e_sum += int'(obs_a[k].e) + int'(obs_b[k].e);
    end
    check("rst_mid.remainder_valid", v_sum, 0);
    check("rst_mid.remainder_err",   e_sum, 0);
    stim.delete(); add_frame(20, 2'b11, 6);  run_episode("after_reset");

    // Randomized episodes.
    for (int r = 0; r < 40; r++) begin
      stim.delete();
      repeat ($urandom_range(0, 2)) stim.push_back(2'b00);
      case ($urandom_range(0, 3))
        0: add_frame($urandom_range(1, 35), 2'b11, $urandom_range(0, 14));
        1: add_frame($urandom_range(1, 35), 2'($urandom_range(0, 3)), $urandom_range(0, 6));
        2: begin
          add_frame($urandom_range(14, 33), 2'b11, $urandom_range(0, 12));
          stim[$urandom_range(0, stim.size() - 1)] = 2'($urandom_range(0, 3));
        end
        default: repeat ($urandom_range(1, 10)) stim.push_back(2'($urandom_range(0, 3)));
      endcase
      run_episode($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ether_rx.md
# ether_rx

RMII receive front end for the Ethernet receive path. Samples the PHY's 2-bit `rxd` bus qualified by `crsdv`, and locates the preamble and start-of-frame delimiter (SFD). It then forwards only the post-SFD frame dibits, in wire order (LSB-first within each byte), as a valid/data stream. The next stage is the bitorder stage, which reorders dibits within each byte.

## Interface
- `MIN_PREAMBLE`, default 16: minimum count of `01` dibits (SFD's leading `01` dibits included) required before the SFD-terminating `11`; range 1..31.
- `MAX_FRAME_DIBITS`, default 6088: maximum payload dibits forwarded per frame (1522 bytes × 4); range 1..8191.
- `clk` input 1: 50 MHz RMII reference clock; all logic on its rising edge. One clock; reset is synchronous and active-low.
- `rst_n` input 1: synchronous, active-low reset.
- `crsdv` input 1: RMII carrier-sense/data-valid from the PHY.
- `rxd` input 2: RMII receive dibit.
- `axiov` output 1: output dibit valid.
- `axiod` output 2: output dibit, wire order.
- `err` output 1: one-cycle pulse on a preamble/SFD failure or frame truncation.

## Operation
- States: IDLE, PREAMBLE, DATA, DROP. Internal counters: `pre_cnt` is 5 bits and saturates at 31; `dat_cnt` is 13 bits.
- IDLE:
  - `crsdv`=1 and `rxd`=`01`: go to PREAMBLE with `pre_cnt`=1.
  - `crsdv`=1 and `rxd`=`00`: stay in IDLE (PHY pre-carrier idle).
  - `crsdv`=1 and `rxd`=`10`/`11`: go to DROP and pulse `err`.
  - `crsdv`=0: stay in IDLE.
- PREAMBLE:
  - `crsdv`=0: go to IDLE and pulse `err`.
  - `rxd`=`01`: increment `pre_cnt` (saturating).
  - `rxd`=`11` with `pre_cnt` ≥ `MIN_PREAMBLE`: go to DATA with `dat_cnt`=0. The SFD dibit is not forwarded.
  - `rxd`=`11` with `pre_cnt` < `MIN_PREAMBLE`: go to DROP and pulse `err`.
  - `rxd`=`00` or `10`: go to DROP and pulse `err`.
- DATA:
  - Each cycle with `crsdv`=1: forward `rxd` and increment `dat_cnt`.
  - `crsdv`=0: the frame ends; go to IDLE with nothing forwarded. This is not an error.
  - A dibit arriving while `dat_cnt` = `MAX_FRAME_DIBITS` is not forwarded; go to DROP and pulse `err`.
- DROP: forward nothing. Leave for IDLE on the first cycle with `crsdv`=0.
- No byte alignment is checked. Trailing partial bytes are forwarded as received; downstream handles them.
- `err` pulses at most once per carrier episode.

## Timing
- Reset (`rst_n`=0 at a clock edge): state=IDLE, `pre_cnt`=0, `dat_cnt`=0, `axiov`=0, `axiod`=`00`, `err`=0. Reset applies mid-frame too; the current frame is abandoned without `err`.
- After reset release while `crsdv`=1: stays in IDLE until `crsdv`=0 or `rxd`=`01`. There is no partial-frame recovery; a mid-frame dibit `01` re-enters PREAMBLE and will normally error out to DROP.
- All outputs are registered. Latency is exactly 1 cycle: a dibit sampled at edge N appears on `axiod` with `axiov`=1 during cycle N+1.
- `axiov` is high for exactly one cycle per forwarded dibit and is contiguous within a frame. It drops 1 cycle after the first `crsdv`=0 sample.
- `axiod` holds its last value when `axiov`=0.
- `err` is asserted in the cycle after the offending sample, for one cycle.
- There is no backpressure; downstream must accept every valid dibit.
- Back-to-back frames: `crsdv` low for one cycle is enough to return to IDLE. The next frame's first `01` is accepted on the following edge.

## Test plan
- Good frame, default parameters:
  - Stimulus: 31×`01`, `11`, then 8 data dibits `00,01,10,11,11,10,01,00`, then `crsdv`=0.
  - Required: `axiov` high for exactly 8 cycles, starting 1 cycle after the first data dibit, with the same 8 dibits in order; `err` never asserted.
- Short preamble, `MIN_PREAMBLE`=16:
  - Stimulus: 10×`01`, `11`, then 4 data dibits.
  - Required: one `err` pulse, `axiov` never high; the next good frame is forwarded normally.
- Bad dibit in preamble:
  - Stimulus: 20×`01`, `10`, `11`, then data.
  - Required: one `err` pulse 1 cycle after the `10`, nothing forwarded, return to IDLE after `crsdv`=0.
- Truncation, `MAX_FRAME_DIBITS`=8:
  - Stimulus: good preamble/SFD, then 12 data dibits.
  - Required: exactly 8 dibits forwarded, one `err` pulse on the 9th, no further output until the next frame.
- Reset mid-DATA:
  - Stimulus: `rst_n`=0 for 1 cycle after 3 data dibits, then the remaining dibits with `crsdv` still high.
  - Required: `axiov`=0 and `axiod`=`00` the cycle after the reset edge, nothing forwarded from the remainder, and no `err` pulse, including from a stray mid-frame `01`, until `crsdv`=0.
- Back-to-back frames separated by one `crsdv`=0 cycle:
  - Required: both frames' data forwarded intact, with `axiov` low for ≥1 cycle between them.
